// File: rtl/alu_btn_frontend.sv
// Board-side command issuer for the 8-bit ALU: synchronizes and debounces
// the execute/clear buttons and issues one-cycle strobes with latched operands.

module btn_debounce #(
   parameter int DB_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic s,
   output logic rise,
   output logic busy
);

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      HELD,
      REL_WAIT
   } db_state_t;

   localparam logic [19:0] CNT_LAST = 20'(DB_CYCLES - 1);

   db_state_t   state;
   db_state_t   state_nx;
   logic [19:0] cnt;
   logic [19:0] cnt_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      rise     = 1'b0;
      unique case (state)
         IDLE: begin
            if (s) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!s) begin
               state_nx = IDLE;
            end else if (cnt == CNT_LAST) begin
               state_nx = HELD;
               rise     = 1'b1;
            end else begin
               cnt_nx = cnt + 20'd1;
            end
         end
         HELD: begin
            if (!s) begin
               state_nx = REL_WAIT;
               cnt_nx   = '0;
            end
         end
         REL_WAIT: begin
            if (s) begin
               state_nx = HELD;
            end else if (cnt == CNT_LAST) begin
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt + 20'd1;
            end
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

module alu_btn_frontend #(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 1000000,
   parameter int OP_W        = 4,
   parameter int DATA_W      = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btnC_raw,
   input  logic              btnU_raw,
   input  logic [OP_W-1:0]   sw_op,
   input  logic [DATA_W-1:0] sw_data,
   output logic              exec_pulse,
   output logic              clr_pulse,
   output logic [OP_W-1:0]   op_sel,
   output logic [DATA_W-1:0] input_bits,
   output logic [7:0]        cmd_count
);

   logic [SYNC_STAGES-1:0] c_sync;
   logic [SYNC_STAGES-1:0] u_sync;
   logic                   c_rise;
   logic                   c_busy;
   logic                   u_rise;
   logic                   u_busy;
   logic                   exec_ok;

   always_ff @(posedge clk) begin
      if (rst) begin
         c_sync <= '0;
         u_sync <= '0;
      end else begin
         c_sync <= {c_sync[SYNC_STAGES-2:0], btnC_raw};
         u_sync <= {u_sync[SYNC_STAGES-2:0], btnU_raw};
      end
   end

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_exec (
      .clk  (clk),
      .rst  (rst),
      .s    (c_sync[SYNC_STAGES-1]),
      .rise (c_rise),
      .busy (c_busy)
   );

   btn_debounce #(
      .DB_CYCLES (DB_CYCLES)
   ) u_db_clr (
      .clk  (clk),
      .rst  (rst),
      .s    (u_sync[SYNC_STAGES-1]),
      .rise (u_rise),
      .busy (u_busy)
   );

   // any clear activity, including a simultaneous qualification, swallows exec
   assign exec_ok = c_rise & ~u_busy;

   always_ff @(posedge clk) begin
      if (rst) begin
         exec_pulse <= 1'b0;
         clr_pulse  <= 1'b0;
         op_sel     <= '0;
         input_bits <= '0;
         cmd_count  <= '0;
      end else begin
         exec_pulse <= exec_ok;
         clr_pulse  <= u_rise;
         if (u_rise) begin
            cmd_count <= '0;
         end else if (exec_ok) begin
            cmd_count  <= cmd_count + 8'd1;
            op_sel     <= sw_op;
            input_bits <= sw_data;
         end
      end
   end

   logic unused_ok;
   assign unused_ok = c_busy;

endmodule

// File: tb/tb_alu_btn_frontend.sv
// Randomized bench for alu_btn_frontend against a run-length
// button model, plus directed latency/priority/wrap checks.

module tb_alu_btn_frontend;

   localparam int SYNC = 2;
   localparam int DB   = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       btnC_raw;
   logic       btnU_raw;
   logic [3:0] sw_op;
   logic [7:0] sw_data;
   logic       exec_pulse;
   logic       clr_pulse;
   logic [3:0] op_sel;
   logic [7:0] input_bits;
   logic [7:0] cmd_count;

   alu_btn_frontend #(
      .SYNC_STAGES (SYNC),
      .DB_CYCLES   (DB),
      .OP_W        (4),
      .DATA_W      (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btnC_raw   (btnC_raw),
      .btnU_raw   (btnU_raw),
      .sw_op      (sw_op),
      .sw_data    (sw_data),
      .exec_pulse (exec_pulse),
      .clr_pulse  (clr_pulse),
      .op_sel     (op_sel),
      .input_bits (input_bits),
      .cmd_count  (cmd_count)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int exec_seen = 0;
   int clr_seen = 0;
   int last_exec = -1;

   bit       qc[$];
   bit       qu[$];
   bit       c_held, u_held;
   int       c_run, u_run;
   bit       m_exec, m_clr;
   bit [3:0] m_op;
   bit [7:0] m_data;
   bit [7:0] m_cnt;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  tag, got, exp, cyc);
      end
   endtask

   // a button flips after DB+1 consecutive synchronized samples of the other level
   task automatic db_step(inout bit held, inout int run, input bit s,
                          output bit fire);
      fire = 1'b0;
      if (s != held) run++;
      else run = 0;
      if (run == DB + 1) begin
         held = s;
         run  = 0;
         fire = s;
      end
   endtask

   task automatic model_edge();
      bit sc, su, clr_active, cf, uf;
      if (rst) begin
         qc = {};
         qu = {};
         repeat (SYNC) begin
            qc.push_back(1'b0);
            qu.push_back(1'b0);
         end
         c_held = 0; u_held = 0; c_run = 0; u_run = 0;
         m_exec = 0; m_clr = 0; m_op = 0; m_data = 0; m_cnt = 0;
      end else begin
         sc = qc.pop_front();
         qc.push_back(btnC_raw);
         su = qu.pop_front();
         qu.push_back(btnU_raw);
         clr_active = u_held || (u_run > 0);
         db_step(c_held, c_run, sc, cf);
         db_step(u_held, u_run, su, uf);
         m_clr  = uf;
         m_exec = cf && !clr_active;
         if (uf) begin
            m_cnt = 0;
         end else if (m_exec) begin
            m_cnt  = m_cnt + 8'd1;
            m_op   = sw_op;
            m_data = sw_data;
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      chk("exec_pulse", 32'(exec_pulse), 32'(m_exec));
      chk("clr_pulse", 32'(clr_pulse), 32'(m_clr));
      chk("op_sel", 32'(op_sel), 32'(m_op));
      chk("input_bits", 32'(input_bits), 32'(m_data));
      chk("cmd_count", 32'(cmd_count), 32'(m_cnt));
      if (exec_pulse === 1'b1) begin
         exec_seen++;
         last_exec = cyc;
      end
      if (clr_pulse === 1'b1) clr_seen++;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   initial begin
      int       ref_cyc, e0, c0;
      logic [3:0] op_keep;

      rst = 1; btnC_raw = 1; btnU_raw = 0; sw_op = 4'h3; sw_data = 8'h11;
      ticks(2);
      chk("rst_exec", 32'(exec_pulse), 32'd0);
      chk("rst_count", 32'(cmd_count), 32'd0);
      chk("rst_op", 32'(op_sel), 32'd0);
      ref_cyc = cyc; e0 = exec_seen;
      rst = 0;
      ticks(12);
      chk("rst_lat", 32'(last_exec - ref_cyc), 32'd7);
      chk("rst_once", 32'(exec_seen - e0), 32'd1);
      btnC_raw = 0;
      ticks(10);

      rst = 1; tick(); rst = 0; tick();
      sw_op = 4'hF; sw_data = 8'hA5;
      ref_cyc = cyc; e0 = exec_seen;
      btnC_raw = 1;
      ticks(20);
      chk("press_lat", 32'(last_exec - ref_cyc), 32'd7);
      chk("press_op", 32'(op_sel), 32'hF);
      chk("press_data", 32'(input_bits), 32'hA5);
      chk("press_count", 32'(cmd_count), 32'd1);
      btnC_raw = 0;
      ticks(12);
      chk("release_nopulse", 32'(exec_seen - e0), 32'd1);

      e0 = exec_seen;
      btnC_raw = 1; tick();
      btnC_raw = 0; tick();
      btnC_raw = 1; tick();
      btnC_raw = 0; tick();
      btnC_raw = 1;
      ref_cyc = cyc;
      sw_data = 8'h3C;
      ticks(15);
      chk("bounce_once", 32'(exec_seen - e0), 32'd1);
      chk("bounce_lat", 32'(last_exec - ref_cyc), 32'd7);
      sw_data = 8'hC3;
      ticks(4);
      chk("data_hold", 32'(input_bits), 32'h3C);
      btnC_raw = 0;
      ticks(12);

      e0 = exec_seen; c0 = clr_seen; op_keep = op_sel;
      sw_op = 4'h6;
      btnC_raw = 1; btnU_raw = 1;
      ticks(15);
      btnC_raw = 0; btnU_raw = 0;
      ticks(12);
      chk("prio_clr", 32'(clr_seen - c0), 32'd1);
      chk("prio_noexec", 32'(exec_seen - e0), 32'd0);
      chk("prio_count", 32'(cmd_count), 32'd0);
      chk("prio_op", 32'(op_sel), 32'(op_keep));

      btnC_raw = 1;
      ticks(4);
      e0 = exec_seen;
      rst = 1; tick(); rst = 0;
      ref_cyc = cyc;
      ticks(6);
      chk("midrst_early", 32'(exec_seen - e0), 32'd0);
      chk("midrst_count0", 32'(cmd_count), 32'd0);
      ticks(6);
      chk("midrst_lat", 32'(last_exec - ref_cyc), 32'd7);
      chk("midrst_once", 32'(exec_seen - e0), 32'd1);
      btnC_raw = 0;
      ticks(12);

      btnU_raw = 1; ticks(10);
      btnU_raw = 0; ticks(10);
      for (int i = 0; i < 256; i++) begin
         sw_op = 4'($urandom);
         sw_data = 8'($urandom);
         btnC_raw = 1;
         ticks($urandom_range(8, 10));
         chk("wrap_step", 32'(cmd_count), 32'((i + 1) % 256));
         btnC_raw = 0;
         ticks($urandom_range(8, 10));
      end
      chk("wrap_zero", 32'(cmd_count), 32'd0);

      repeat (120) begin
         btnC_raw = 1'($urandom_range(0, 1));
         btnU_raw = ($urandom_range(0, 3) == 0);
         sw_op = 4'($urandom);
         sw_data = 8'($urandom);
         rst = ($urandom_range(0, 19) == 0);
         ticks($urandom_range(1, 12));
         rst = 0;
      end
      btnC_raw = 0; btnU_raw = 0;
      ticks(12);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
